// File: rtl/game_pkg.sv
// Shared game-flow definitions: phase encoding, lives width and the default
// game constants used by the sequencer and the collision/position controllers.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLAY   = 2'd1,
    FREEZE = 2'd2,
    OVER   = 2'd3
  } game_state_e;

  localparam int LIVES_W           = 3;
  localparam int FREEZE_W          = 8;
  localparam int DIV_W             = 4;
  localparam int LIVES_INIT_DEF    = 7;
  localparam int FREEZE_FRAMES_DEF = 60;

endpackage

// File: rtl/game_sequencer_tick_divider.sv
// Frame-tick divider: 4-bit counter whose terminal tick (the N-th) is flagged
// combinationally so the caller can register it alongside its own arbitration.
module tick_divider
  import game_pkg::*;
#(
  parameter int N = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic tick,
  output logic pulse
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(N - 1);

  logic [DIV_W-1:0] cnt_r;

  assign pulse = tick & (cnt_r == LAST);

  // Count ticks, wrap after the terminal one; clear has priority over counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {DIV_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {DIV_W{1'b0}};
    end else if (tick) begin
      if (cnt_r == LAST) begin
        cnt_r <= {DIV_W{1'b0}};
      end else begin
        cnt_r <= cnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Game-flow controller: phase FSM, lives, post-hit freeze with sprite flash,
// and the move/respawn pulses that drive the object-position datapath.
module game_sequencer
  import game_pkg::*;
#(
  parameter int LIVES_INIT    = LIVES_INIT_DEF,
  parameter int FREEZE_FRAMES = FREEZE_FRAMES_DEF,
  parameter int MOVE_DIV      = 1,
  parameter int SCORE_W       = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               hit,
  output logic [1:0]         state,
  output logic               move_en,
  output logic               respawn,
  output logic [2:0]         lives,
  output logic [SCORE_W-1:0] score,
  output logic               flash
);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_PLAY   = PLAY;
  localparam logic [1:0] S_FREEZE = FREEZE;
  localparam logic [1:0] S_OVER   = OVER;

  localparam logic [LIVES_W-1:0]  LIVES_LOAD  = LIVES_W'(LIVES_INIT);
  localparam logic [FREEZE_W-1:0] FREEZE_LOAD = FREEZE_W'(FREEZE_FRAMES);
  localparam logic [SCORE_W-1:0]  SCORE_ONE   = {{(SCORE_W-1){1'b0}}, 1'b1};

  logic [1:0]          state_r, state_s;
  logic [LIVES_W-1:0]  lives_r, lives_s;
  logic [SCORE_W-1:0]  score_r, score_s;
  logic [FREEZE_W-1:0] freeze_cnt_r, freeze_cnt_s;
  logic                move_en_r, move_en_s;
  logic                respawn_r, respawn_s;
  logic                flash_r, flash_s;
  logic                start_q_r;
  logic                start_rise_s;
  logic                freeze_done_s;
  logic                div_clr_s;
  logic                div_tick_s;
  logic                div_pulse_s;

  assign start_rise_s  = start & ~start_q_r;
  assign freeze_done_s = (state_r == S_FREEZE) & frame_tick & (freeze_cnt_r == 8'd1);
  assign div_tick_s    = (state_r == S_PLAY) & frame_tick;
  assign div_clr_s     = ((state_r == S_IDLE) & start_rise_s) |
                         ((state_r == S_PLAY) & hit) |
                         freeze_done_s;

  tick_divider #(.N(MOVE_DIV)) u_move_div (
    .clk   (clk),
    .rst   (rst),
    .clr   (div_clr_s),
    .tick  (div_tick_s),
    .pulse (div_pulse_s)
  );

  // Next-state logic for phase, lives, score, freeze/flash and output pulses.
  always_comb begin
    state_s      = state_r;
    lives_s      = lives_r;
    score_s      = score_r;
    freeze_cnt_s = freeze_cnt_r;
    flash_s      = flash_r;
    move_en_s    = 1'b0;
    respawn_s    = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start_rise_s) begin
          state_s   = S_PLAY;
          lives_s   = LIVES_LOAD;
          score_s   = {SCORE_W{1'b0}};
          respawn_s = 1'b1;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_PLAY: begin
        // A hit outranks a coincident move tick: no step, no score.
        if (hit) begin
          if (lives_r == 3'd1) begin
            lives_s = 3'd0;
            state_s = S_OVER;
          end else begin
            lives_s      = lives_r - 3'd1;
            state_s      = S_FREEZE;
            freeze_cnt_s = FREEZE_LOAD;
          end
        end else if (div_pulse_s) begin
          move_en_s = 1'b1;
          if (score_r != {SCORE_W{1'b1}}) begin
            score_s = score_r + SCORE_ONE;
          end else begin
            score_s = score_r;
          end
        end else begin
          move_en_s = 1'b0;
        end
      end
      S_FREEZE: begin
        if (frame_tick) begin
          freeze_cnt_s = freeze_cnt_r - 8'd1;
          if (freeze_cnt_r == 8'd1) begin
            respawn_s = 1'b1;
            flash_s   = 1'b0;
            state_s   = S_PLAY;
          end else if (freeze_cnt_r[2:0] == 3'd0) begin
            flash_s = ~flash_r;
          end else begin
            flash_s = flash_r;
          end
        end else begin
          freeze_cnt_s = freeze_cnt_r;
        end
      end
      S_OVER: begin
        if (start_rise_s) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_OVER;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= S_IDLE;
      lives_r      <= LIVES_LOAD;
      score_r      <= {SCORE_W{1'b0}};
      freeze_cnt_r <= 8'd0;
      move_en_r    <= 1'b0;
      respawn_r    <= 1'b0;
      flash_r      <= 1'b0;
      start_q_r    <= 1'b0;
    end else begin
      state_r      <= state_s;
      lives_r      <= lives_s;
      score_r      <= score_s;
      freeze_cnt_r <= freeze_cnt_s;
      move_en_r    <= move_en_s;
      respawn_r    <= respawn_s;
      flash_r      <= flash_s;
      start_q_r    <= start;
    end
  end

  assign state   = state_r;
  assign lives   = lives_r;
  assign score   = score_r;
  assign move_en = move_en_r;
  assign respawn = respawn_r;
  assign flash   = flash_r;

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: randomized stimulus, behavioural game
// model pushes expected outputs; a monitor pops and compares every cycle.
module tb_game_sequencer;

  localparam int LI   = 3;
  localparam int FF   = 12;
  localparam int MD   = 3;
  localparam int SW   = 4;
  localparam int SMAX = (1 << SW) - 1;

  localparam int P_IDLE   = 0;
  localparam int P_PLAY   = 1;
  localparam int P_FREEZE = 2;
  localparam int P_OVER   = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          frame_tick = 1'b0;
  logic          start = 1'b0;
  logic          hit = 1'b0;
  logic [1:0]    state;
  logic          move_en;
  logic          respawn;
  logic [2:0]    lives;
  logic [SW-1:0] score;
  logic          flash;

  game_sequencer #(
    .LIVES_INIT    (LI),
    .FREEZE_FRAMES (FF),
    .MOVE_DIV      (MD),
    .SCORE_W       (SW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .start      (start),
    .hit        (hit),
    .state      (state),
    .move_en    (move_en),
    .respawn    (respawn),
    .lives      (lives),
    .score      (score),
    .flash      (flash)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]    st;
    logic [2:0]    lv;
    logic [SW-1:0] sc;
    logic          mv;
    logic          rs;
    logic          fl;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  // behavioural game model
  int m_phase, m_lives, m_score, m_ticks, m_left;
  bit m_mv, m_rs, m_fl, m_prev_start;

  function automatic exp_t snap();
    exp_t e;
    e.st = 2'(m_phase);
    e.lv = 3'(m_lives);
    e.sc = SW'(m_score);
    e.mv = m_mv;
    e.rs = m_rs;
    e.fl = m_fl;
    return e;
  endfunction

  function automatic exp_t reset_snap();
    exp_t e;
    e.st = 2'(P_IDLE);
    e.lv = 3'(LI);
    e.sc = '0;
    e.mv = 1'b0;
    e.rs = 1'b0;
    e.fl = 1'b0;
    return e;
  endfunction

  task automatic model_step(input bit r, input bit s, input bit t, input bit h);
    bit rise;
    if (r) begin
      m_phase = P_IDLE; m_lives = LI; m_score = 0; m_ticks = 0; m_left = 0;
      m_mv = 0; m_rs = 0; m_fl = 0; m_prev_start = 0;
      return;
    end
    rise = s && !m_prev_start;
    m_prev_start = s;
    m_mv = 0;
    m_rs = 0;
    if (m_phase == P_IDLE) begin
      if (rise) begin
        m_phase = P_PLAY; m_lives = LI; m_score = 0; m_ticks = 0; m_rs = 1;
      end
    end else if (m_phase == P_PLAY) begin
      if (h) begin
        m_ticks = 0;
        m_lives = m_lives - 1;
        if (m_lives == 0) m_phase = P_OVER;
        else begin
          m_phase = P_FREEZE;
          m_left  = FF;
        end
      end else if (t) begin
        m_ticks = m_ticks + 1;
        if (m_ticks == MD) begin
          m_ticks = 0;
          m_mv    = 1;
          m_score = (m_score < SMAX) ? m_score + 1 : SMAX;
        end
      end
    end else if (m_phase == P_FREEZE) begin
      if (t) begin
        if (m_left == 1) begin
          m_rs = 1; m_fl = 0; m_ticks = 0; m_phase = P_PLAY; m_left = 0;
        end else begin
          if (m_left % 8 == 0) m_fl = !m_fl;
          m_left = m_left - 1;
        end
      end
    end else begin
      if (rise) m_phase = P_IDLE;
    end
  endtask

  task automatic compare(input string name, input exp_t got, input exp_t e);
    total++;
    if (got !== e) begin
      bad++;
      $display("FAIL %s t=%0t got st=%0d lv=%0d sc=%0d mv=%b rs=%b fl=%b exp st=%0d lv=%0d sc=%0d mv=%b rs=%b fl=%b",
               name, $time, got.st, got.lv, got.sc, got.mv, got.rs, got.fl,
               e.st, e.lv, e.sc, e.mv, e.rs, e.fl);
    end
  endtask

  function automatic exp_t dut_out();
    exp_t g;
    g.st = state; g.lv = lives; g.sc = score;
    g.mv = move_en; g.rs = respawn; g.fl = flash;
    return g;
  endfunction

  task automatic drive(input bit r, input bit s, input bit t, input bit h);
    bit was_rst;
    @(negedge clk);
    was_rst = rst;
    rst = r; start = s; frame_tick = t; hit = h;
    model_step(r, s, t, h);
    exp_q.push_back(snap());
    if (r && !was_rst) begin
      #1;
      compare("reset_now", dut_out(), reset_snap());
    end
  endtask

  // monitor: outputs after each active edge against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        compare("cycle", dut_out(), e);
      end
    end
  end

  initial begin
    bit s_lvl;
    s_lvl = 0;
    repeat (3) drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 0, 1, 0);
    drive(0, 0, 0, 1);
    drive(1, 0, 1, 0);
    drive(0, 0, 0, 0);

    drive(0, 1, 0, 0);
    drive(0, 1, 1, 0);
    drive(0, 0, 0, 0);
    for (int i = 0; i < 120; i++)
      drive(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);

    for (int i = 0; i < 10 && m_ticks != MD - 1; i++) drive(0, 0, 1, 0);
    drive(0, 0, 1, 1);
    for (int i = 0; i < 40; i++)
      drive(0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    for (int i = 0; i < 400 && m_phase != P_OVER; i++)
      drive(0, 0, 1'($urandom_range(0, 1)),
            (m_phase == P_PLAY) && ($urandom_range(0, 5) == 0));
    for (int i = 0; i < 10; i++)
      drive(0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    drive(0, 1, 0, 0);
    drive(0, 0, 1, 1);
    drive(0, 1, 1, 0);
    drive(0, 0, 0, 0);

    for (int i = 0; i < 4; i++) drive(0, 0, 1, 0);
    drive(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) drive(0, 0, 1, 0);
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 1, 0);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) s_lvl = !s_lvl;
      drive($urandom_range(0, 399) == 0, s_lvl,
            $urandom_range(0, 2) == 0, $urandom_range(0, 11) == 0);
    end
    repeat (3) drive(0, 0, 0, 0);
    @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
